// File: rtl/pipe_pkg.sv
// Shared pipeline constants: forwarding-mux select encodings and register-index width.
// Imported by fwd_select and fwd_hazard_ctrl.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding select for one EX-stage operand.
// The younger EX/MEM result wins over MEM/WB, and $0 is never forwarded.
module fwd_select #(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] src,
    input  logic              exmem_rw,
    input  logic [ADDR_W-1:0] exmem_dest,
    input  logic              memwb_rw,
    input  logic [ADDR_W-1:0] memwb_dest,
    output logic [1:0]        sel
);
    import pipe_pkg::*;

    logic exmem_hit;
    logic memwb_hit;

    assign exmem_hit = exmem_rw && (exmem_dest != ADDR_W'(REG_ZERO)) && (exmem_dest == src);
    assign memwb_hit = memwb_rw && (memwb_dest != ADDR_W'(REG_ZERO)) && (memwb_dest == src);

    always_comb begin
        sel = FWD_REG;
        if (exmem_hit) begin
            sel = FWD_EXMEM;
        end else if (memwb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use / branch-squash controller for the 5-stage pipeline.
// Optional macro ID_BYPASS_EN adds ID-stage write-back bypass outputs.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ID_rs_in,
    input  logic [REG_ADDR_W-1:0] ID_rt_in,
    input  logic                  ID_uses_rs_in,
    input  logic                  ID_uses_rt_in,
    input  logic [REG_ADDR_W-1:0] ID_dest_in,
    input  logic                  ID_reg_write_in,
    input  logic                  ID_mem_read_in,
    input  logic                  Branch_taken_in,
    output logic [1:0]            Forward_A_out,
    output logic [1:0]            Forward_B_out,
    output logic                  Stall_out,
    output logic                  Bubble_out,
    output logic                  Flush_out,
`ifdef ID_BYPASS_EN
    output logic                  ID_bypass_A_out,
    output logic                  ID_bypass_B_out,
`endif
    output logic [PERF_W-1:0]     Stall_count_out
);
    import pipe_pkg::*;

    logic [REG_ADDR_W-1:0] idex_rs_reg;
    logic [REG_ADDR_W-1:0] idex_rt_reg;
    logic [REG_ADDR_W-1:0] idex_dest_reg;
    logic                  idex_rw_reg;
    logic                  idex_mr_reg;
    logic [REG_ADDR_W-1:0] exmem_dest_reg;
    logic                  exmem_rw_reg;
    logic [REG_ADDR_W-1:0] memwb_dest_reg;
    logic                  memwb_rw_reg;
    logic [PERF_W-1:0]     stall_count_reg;
    logic [PERF_W-1:0]     stall_count_next;

    logic                  load_use_hz;
    logic [REG_ADDR_W-1:0] idex_src [2];
    logic [1:0]            fwd_sel  [2];

    assign idex_src[0] = idex_rs_reg;
    assign idex_src[1] = idex_rt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select #(
                .ADDR_W(REG_ADDR_W)
            ) u_fwd_select (
                .src       (idex_src[gi]),
                .exmem_rw  (exmem_rw_reg),
                .exmem_dest(exmem_dest_reg),
                .memwb_rw  (memwb_rw_reg),
                .memwb_dest(memwb_dest_reg),
                .sel       (fwd_sel[gi])
            );
        end
    endgenerate

    assign Forward_A_out = fwd_sel[0];
    assign Forward_B_out = fwd_sel[1];

    assign load_use_hz = idex_mr_reg && idex_rw_reg && (idex_dest_reg != REG_ADDR_W'(REG_ZERO)) &&
                         ((ID_uses_rs_in && (idex_dest_reg == ID_rs_in)) ||
                          (ID_uses_rt_in && (idex_dest_reg == ID_rt_in)));

    // A taken branch discards the ID instruction, so a coincident load-use needs no stall.
    always_comb begin
        Stall_out  = 1'b0;
        Bubble_out = 1'b0;
        Flush_out  = 1'b0;
        if (Branch_taken_in) begin
            Flush_out  = 1'b1;
            Bubble_out = 1'b1;
        end else if (load_use_hz) begin
            Stall_out  = 1'b1;
            Bubble_out = 1'b1;
        end
    end

    always_comb begin
        stall_count_next = stall_count_reg;
        if (Stall_out && (stall_count_reg != {PERF_W{1'b1}})) begin
            stall_count_next = stall_count_reg + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_rs_reg     <= '0;
            idex_rt_reg     <= '0;
            idex_dest_reg   <= '0;
            idex_rw_reg     <= 1'b0;
            idex_mr_reg     <= 1'b0;
            exmem_dest_reg  <= '0;
            exmem_rw_reg    <= 1'b0;
            memwb_dest_reg  <= '0;
            memwb_rw_reg    <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            memwb_dest_reg  <= exmem_dest_reg;
            memwb_rw_reg    <= exmem_rw_reg;
            exmem_dest_reg  <= idex_dest_reg;
            exmem_rw_reg    <= idex_rw_reg;
            stall_count_reg <= stall_count_next;
            if (Bubble_out) begin
                idex_rs_reg   <= '0;
                idex_rt_reg   <= '0;
                idex_dest_reg <= '0;
                idex_rw_reg   <= 1'b0;
                idex_mr_reg   <= 1'b0;
            end else begin
                idex_rs_reg   <= ID_rs_in;
                idex_rt_reg   <= ID_rt_in;
                idex_dest_reg <= ID_dest_in;
                idex_rw_reg   <= ID_reg_write_in;
                idex_mr_reg   <= ID_mem_read_in;
            end
        end
    end

    assign Stall_count_out = stall_count_reg;

`ifdef ID_BYPASS_EN
    assign ID_bypass_A_out = memwb_rw_reg && (memwb_dest_reg != REG_ADDR_W'(REG_ZERO)) &&
                             (memwb_dest_reg == ID_rs_in);
    assign ID_bypass_B_out = memwb_rw_reg && (memwb_dest_reg != REG_ADDR_W'(REG_ZERO)) &&
                             (memwb_dest_reg == ID_rt_in);
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl: forwarding, load-use stall, branch squash,
// reset mid-stall and counter saturation (second instance with PERF_W=4).
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_urs, id_urt, id_rw, id_mr, br;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, bubble, flush;
    logic [31:0] cnt;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic        s_stall, s_bubble, s_flush;
    logic [3:0]  s_cnt;
`ifdef ID_BYPASS_EN
    logic        byp_a, byp_b, s_byp_a, s_byp_b;
`endif

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .ID_rs_in(id_rs), .ID_rt_in(id_rt),
        .ID_uses_rs_in(id_urs), .ID_uses_rt_in(id_urt),
        .ID_dest_in(id_dest), .ID_reg_write_in(id_rw), .ID_mem_read_in(id_mr),
        .Branch_taken_in(br),
        .Forward_A_out(fwd_a), .Forward_B_out(fwd_b),
        .Stall_out(stall), .Bubble_out(bubble), .Flush_out(flush),
`ifdef ID_BYPASS_EN
        .ID_bypass_A_out(byp_a), .ID_bypass_B_out(byp_b),
`endif
        .Stall_count_out(cnt)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .ID_rs_in(id_rs), .ID_rt_in(id_rt),
        .ID_uses_rs_in(id_urs), .ID_uses_rt_in(id_urt),
        .ID_dest_in(id_dest), .ID_reg_write_in(id_rw), .ID_mem_read_in(id_mr),
        .Branch_taken_in(br),
        .Forward_A_out(s_fwd_a), .Forward_B_out(s_fwd_b),
        .Stall_out(s_stall), .Bubble_out(s_bubble), .Flush_out(s_flush),
`ifdef ID_BYPASS_EN
        .ID_bypass_A_out(s_byp_a), .ID_bypass_B_out(s_byp_b),
`endif
        .Stall_count_out(s_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dest, input logic rw, input logic mr);
        id_rs = rs; id_rt = rt; id_urs = urs; id_urt = urt;
        id_dest = dest; id_rw = rw; id_mr = mr;
        #1;
    endtask

    task automatic flush_pipe();
        set_id(0, 0, 0, 0, 0, 0, 0);
        br = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; br = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b exp 00", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got %b exp 00", fwd_b); end
        checks++; if ({stall, bubble, flush} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b exp 000", {stall, bubble, flush}); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        checks++; if (s_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt4 got %0d exp 0", s_cnt); end
        rst = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_exmem_memwb_fwd();
        flush_pipe();
        set_id(1, 2, 1, 1, 3, 1, 0);          // add $3,$1,$2
        step();
        set_id(3, 4, 1, 1, 8, 1, 0);          // sub $8,$3,$4
        step();
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL exmem_fwd_a got %b exp 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL exmem_fwd_b got %b exp 00", fwd_b); end
        set_id(3, 1, 1, 1, 9, 0, 0);          // reads $3 again, no write
        step();
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL memwb_fwd_a got %b exp 01", fwd_a); end
        $display("test_exmem_memwb_fwd done");
    endtask

    task automatic test_load_use();
        flush_pipe();
        set_id(1, 0, 1, 0, 5, 1, 1);          // lw $5
        step();
        set_id(5, 7, 1, 1, 6, 1, 0);          // add $6,$5,$7
        checks++; if ({stall, bubble, flush} !== 3'b110) begin errors++; $display("FAIL lu_stall got %b exp 110", {stall, bubble, flush}); end
        step();
        exp_count++;
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL lu_one_cycle got %b exp 00", {stall, bubble}); end
        step();
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got %b exp 01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b got %b exp 00", fwd_b); end
        checks++; if (cnt !== 32'(exp_count)) begin errors++; $display("FAIL lu_cnt got %0d exp %0d", cnt, exp_count); end
        $display("test_load_use done");
    endtask

    task automatic test_reg_zero_and_priority();
        flush_pipe();
        set_id(1, 2, 1, 1, 0, 1, 0);          // writes $0
        step();
        set_id(0, 0, 1, 0, 0, 0, 0);          // reads $0
        step();
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL zero_fwd_a got %b exp 00", fwd_a); end
        flush_pipe();
        set_id(1, 2, 1, 1, 4, 1, 0);          // writes $4 (older)
        step();
        set_id(1, 2, 1, 1, 4, 1, 0);          // writes $4 (younger)
        step();
        set_id(0, 4, 0, 1, 0, 0, 0);          // reads rt=$4
        step();
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL prio_fwd_b got %b exp 10", fwd_b); end
        step();
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL memwb_only_fwd_b got %b exp 01", fwd_b); end
        $display("test_reg_zero_and_priority done");
    endtask

    task automatic test_branch_over_hazard();
        flush_pipe();
        set_id(1, 0, 1, 0, 5, 1, 1);          // lw $5
        step();
        set_id(5, 7, 1, 1, 6, 1, 0);
        br = 1'b1; #1;
        checks++; if ({stall, bubble, flush} !== 3'b011) begin errors++; $display("FAIL br_ctl got %b exp 011", {stall, bubble, flush}); end
        step();
        br = 1'b0; #1;
        checks++; if (cnt !== 32'(exp_count)) begin errors++; $display("FAIL br_cnt got %0d exp %0d", cnt, exp_count); end
        checks++; if ({stall, bubble, flush} !== 3'b000) begin errors++; $display("FAIL br_after got %b exp 000", {stall, bubble, flush}); end
        $display("test_branch_over_hazard done");
    endtask

    task automatic test_reset_mid_stall();
        flush_pipe();
        set_id(1, 0, 1, 0, 5, 1, 1);
        step();
        set_id(5, 7, 1, 1, 6, 1, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_rst_stall got %b exp 1", stall); end
        rst = 1'b1;
        step();
        exp_count = 0;
        checks++; if ({stall, bubble, flush} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {stall, bubble, flush}); end
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_fwd got %b exp 0000", {fwd_a, fwd_b}); end
        checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        rst = 1'b0;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_no_pending got %b exp 0", stall); end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_saturation();
        flush_pipe();
        for (int i = 0; i < 20; i++) begin
            set_id(1, 0, 1, 0, 5, 1, 1);
            step();
            set_id(5, 7, 1, 1, 6, 1, 0);
            step();
            exp_count++;
        end
        checks++; if (cnt !== 32'(exp_count)) begin errors++; $display("FAIL sat_cnt32 got %0d exp %0d", cnt, exp_count); end
        checks++; if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt4 got %0d exp 15", s_cnt); end
        $display("test_saturation done");
    endtask

`ifdef ID_BYPASS_EN
    task automatic test_id_bypass();
        flush_pipe();
        set_id(1, 2, 1, 1, 9, 1, 0);          // writes $9
        step();
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        set_id(9, 2, 1, 1, 10, 1, 0);         // ID reads rs=$9 while MEM/WB writes $9
        checks++; if (byp_a !== 1'b1) begin errors++; $display("FAIL byp_a got %b exp 1", byp_a); end
        checks++; if (byp_b !== 1'b0) begin errors++; $display("FAIL byp_b got %b exp 0", byp_b); end
        $display("test_id_bypass done");
    endtask
`endif

    initial begin
        test_reset();
        test_exmem_memwb_fwd();
        test_load_use();
        test_reg_zero_and_priority();
        test_branch_over_hazard();
        test_reset_mid_stall();
        test_saturation();
`ifdef ID_BYPASS_EN
        test_id_bypass();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
